// File: rtl/morph_filter_platedetection.sv
// 3x3 max/min morphology over a raster of packed pixel words, cross or square kernel.
// A sliding window of 2*WPL+3 words holds the rows above and below the word being filtered.

module morph_filter_platedetection #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_WORD = 8,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int DATA_W          = PIXEL_WIDTH * PIXELS_PER_WORD
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_mode,
  input  logic              i_kernel_sel,
  input  logic              i_pixels_data_valid,
  input  logic [DATA_W-1:0] i_pixels_data,
  output logic [DATA_W-1:0] o_pixels_data,
  output logic              o_pixels_data_valid,
  output logic              o_end_frame,
  output logic              o_drop
);

  localparam int PW    = PIXEL_WIDTH;
  localparam int PPW   = PIXELS_PER_WORD;
  localparam int WPL   = FRAME_WIDTH / PIXELS_PER_WORD;
  localparam int H     = FRAME_HEIGHT;
  localparam int DEPTH = 2 * WPL + 3;
  localparam int CW    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int RW    = (H > 1) ? $clog2(H) : 1;

  // Window slots relative to the newest word (slot 0) once the centre word sits at WPL+1.
  localparam int POS_DR = 0;
  localparam int POS_DN = 1;
  localparam int POS_DL = 2;
  localparam int POS_R  = WPL;
  localparam int POS_C  = WPL + 1;
  localparam int POS_L  = WPL + 2;
  localparam int POS_UR = 2 * WPL;
  localparam int POS_U  = 2 * WPL + 1;
  localparam int POS_UL = 2 * WPL + 2;

  localparam logic [CW-1:0] LAST_COL = CW'(WPL - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     inCol_q, inCol_d, outCol_q, outCol_d;
  logic [RW-1:0]     inRow_q, inRow_d, outRow_q, outRow_d;
  logic              mode_q, kernel_q;
  logic [DATA_W-1:0] win_q [DEPTH];

  logic              advValid_q, advTop_q, advBottom_q, advLeft_q, advRight_q;
  logic [DATA_W-1:0] res_q;
  logic              resValid_q, resLast_q;
  logic [DATA_W-1:0] outData_q;
  logic              outValid_q, outEnd_q, drop_q;

  logic              accept, advance, shift;
  logic [PW-1:0]     neutral, acc;
  logic [PW-1:0]     extUp [PPW+2];
  logic [PW-1:0]     extMid[PPW+2];
  logic [PW-1:0]     extDn [PPW+2];
  logic [DATA_W-1:0] filtered;

  function automatic logic [PW-1:0] pxl(input logic [DATA_W-1:0] w, input int idx);
    return w[idx*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] pick(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                         input logic erode);
    if (erode) return (a < b) ? a : b;
    return (a > b) ? a : b;
  endfunction

  // Every shift moves the centre on by one word; FLUSH keeps shifting without input.
  assign accept  = i_pixels_data_valid && (state_q != FLUSH);
  assign advance = (state_q == STREAM && accept) || (state_q == FLUSH);
  assign shift   = accept || (state_q == FLUSH);
  assign neutral = {PW{mode_q}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && inRow_q == ROW_ONE && inCol_q == '0) state_d = STREAM;
      STREAM:  if (accept && inRow_q == LAST_ROW && inCol_q == LAST_COL) state_d = FLUSH;
      FLUSH:   if (outRow_q == LAST_ROW && outCol_q == LAST_COL) state_d = DONE;
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    inCol_d  = inCol_q;
    inRow_d  = inRow_q;
    outCol_d = outCol_q;
    outRow_d = outRow_q;
    if (accept) begin
      if (inCol_q == LAST_COL) begin
        inCol_d = '0;
        inRow_d = (inRow_q == LAST_ROW) ? '0 : inRow_q + ROW_ONE;
      end else begin
        inCol_d = inCol_q + COL_ONE;
      end
    end
    if (advance) begin
      if (outCol_q == LAST_COL) begin
        outCol_d = '0;
        outRow_d = (outRow_q == LAST_ROW) ? '0 : outRow_q + ROW_ONE;
      end else begin
        outCol_d = outCol_q + COL_ONE;
      end
    end
  end

  // Each row is widened by one pixel on each side, replaced by the neutral value outside the frame.
  always_comb begin
    for (int i = 0; i < PPW; i++) begin
      extMid[i+1] = pxl(win_q[POS_C], i);
      extUp[i+1]  = advTop_q    ? neutral : pxl(win_q[POS_U], i);
      extDn[i+1]  = advBottom_q ? neutral : pxl(win_q[POS_DN], i);
    end
    extMid[0]     = advLeft_q                  ? neutral : pxl(win_q[POS_L],  PPW - 1);
    extUp[0]      = (advTop_q || advLeft_q)    ? neutral : pxl(win_q[POS_UL], PPW - 1);
    extDn[0]      = (advBottom_q || advLeft_q) ? neutral : pxl(win_q[POS_DL], PPW - 1);
    extMid[PPW+1] = advRight_q                  ? neutral : pxl(win_q[POS_R],  0);
    extUp[PPW+1]  = (advTop_q || advRight_q)    ? neutral : pxl(win_q[POS_UR], 0);
    extDn[PPW+1]  = (advBottom_q || advRight_q) ? neutral : pxl(win_q[POS_DR], 0);
  end

  always_comb begin
    filtered = '0;
    acc      = '0;
    for (int i = 0; i < PPW; i++) begin
      acc = extMid[i+1];
      acc = pick(acc, extMid[i],   mode_q);
      acc = pick(acc, extMid[i+2], mode_q);
      acc = pick(acc, extUp[i+1],  mode_q);
      acc = pick(acc, extDn[i+1],  mode_q);
      if (kernel_q) begin
        acc = pick(acc, extUp[i],   mode_q);
        acc = pick(acc, extUp[i+2], mode_q);
        acc = pick(acc, extDn[i],   mode_q);
        acc = pick(acc, extDn[i+2], mode_q);
      end
      filtered[i*PW +: PW] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      win_q[0] <= i_pixels_data;
      for (int j = 1; j < DEPTH; j++) win_q[j] <= win_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= FILL;
      inCol_q     <= '0;
      inRow_q     <= '0;
      outCol_q    <= '0;
      outRow_q    <= '0;
      mode_q      <= 1'b0;
      kernel_q    <= 1'b0;
      advValid_q  <= 1'b0;
      advTop_q    <= 1'b0;
      advBottom_q <= 1'b0;
      advLeft_q   <= 1'b0;
      advRight_q  <= 1'b0;
      res_q       <= '0;
      resValid_q  <= 1'b0;
      resLast_q   <= 1'b0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outEnd_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      inCol_q  <= inCol_d;
      inRow_q  <= inRow_d;
      outCol_q <= outCol_d;
      outRow_q <= outRow_d;
      if (accept && inRow_q == '0 && inCol_q == '0) begin
        mode_q   <= i_mode;
        kernel_q <= i_kernel_sel;
      end
      advValid_q <= advance;
      if (advance) begin
        advTop_q    <= (outRow_q == '0);
        advBottom_q <= (outRow_q == LAST_ROW);
        advLeft_q   <= (outCol_q == '0);
        advRight_q  <= (outCol_q == LAST_COL);
      end
      if (advValid_q) res_q <= filtered;
      resValid_q <= advValid_q;
      resLast_q  <= advValid_q && advBottom_q && advRight_q;
      if (resValid_q) outData_q <= res_q;
      outValid_q <= resValid_q;
      outEnd_q   <= resLast_q;
      drop_q     <= (state_q == FLUSH) && i_pixels_data_valid;
    end
  end

  assign o_pixels_data       = outData_q;
  assign o_pixels_data_valid = outValid_q;
  assign o_end_frame         = outEnd_q;
  assign o_drop              = drop_q;

endmodule

// File: tb/tb_morph_filter_platedetection.sv
// Bench for morph_filter_platedetection: a whole-frame reference filter feeds a scoreboard of
// expected words, end-of-frame flags and output cycles, drained by an independent monitor.

module tb_morph_filter_platedetection;

  localparam int PW  = 8;
  localparam int PPW = 4;
  localparam int FW  = 8;
  localparam int H   = 4;
  localparam int WPL = FW / PPW;
  localparam int N   = WPL * H;
  localparam int DW  = PW * PPW;

  logic          clk = 1'b0;
  logic          i_reset, i_mode, i_kernel_sel, i_pixels_data_valid;
  logic [DW-1:0] i_pixels_data;
  logic [DW-1:0] o_pixels_data;
  logic          o_pixels_data_valid, o_end_frame, o_drop;

  morph_filter_platedetection #(
    .PIXEL_WIDTH    (PW),
    .PIXELS_PER_WORD(PPW),
    .FRAME_WIDTH    (FW),
    .FRAME_HEIGHT   (H)
  ) dut (
    .clk                (clk),
    .i_reset            (i_reset),
    .i_mode             (i_mode),
    .i_kernel_sel       (i_kernel_sel),
    .i_pixels_data_valid(i_pixels_data_valid),
    .i_pixels_data      (i_pixels_data),
    .o_pixels_data      (o_pixels_data),
    .o_pixels_data_valid(o_pixels_data_valid),
    .o_end_frame        (o_end_frame),
    .o_drop             (o_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            assertCount = 0;
  int            failCount   = 0;
  logic [DW-1:0] expData[$];
  bit            expLast[$];
  int            expCycle[$];
  int            outSeen = 0, endSeen = 0, dropSeen = 0, expDrops = 0;
  bit            ignoreOut = 1'b0, quiet = 1'b0;
  int            frameBuf[H][FW];
  int            golden[H][FW];

  task automatic checkOutput();
    logic [DW-1:0] d;
    bit            l;
    int            c;
    if (expData.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL unexpected_output: got data=%h at cycle %0d, required no output", o_pixels_data, cyc);
    end else begin
      d = expData.pop_front();
      l = expLast.pop_front();
      assertCount += 3;
      if (o_pixels_data !== d) begin
        failCount++;
        $display("[TB] FAIL data: got %h, required %h (cycle %0d)", o_pixels_data, d, cyc);
      end
      if (o_end_frame !== l) begin
        failCount++;
        $display("[TB] FAIL end_frame: got %0b, required %0b (cycle %0d)", o_end_frame, l, cyc);
      end
      if (expCycle.size() == 0) begin
        failCount++;
        $display("[TB] FAIL latency: output at cycle %0d, required none scheduled", cyc);
      end else begin
        c = expCycle.pop_front();
        if (cyc != c) begin
          failCount++;
          $display("[TB] FAIL latency: output at cycle %0d, required cycle %0d", cyc, c);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (quiet) begin
      assertCount++;
      if (o_pixels_data_valid || o_end_frame || o_drop) begin
        failCount++;
        $display("[TB] FAIL quiet: valid=%0b end=%0b drop=%0b, required all 0",
                 o_pixels_data_valid, o_end_frame, o_drop);
      end
    end
    if (o_drop) dropSeen++;
    if (o_pixels_data_valid) begin
      outSeen++;
      if (o_end_frame) endSeen++;
      if (!ignoreOut) checkOutput();
    end else begin
      assertCount++;
      if (o_end_frame) begin
        failCount++;
        $display("[TB] FAIL end_without_valid: end=1 valid=0 at cycle %0d, required end=0", cyc);
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit m, input bit k);
    i_pixels_data_valid = v;
    i_pixels_data       = d;
    i_mode              = m;
    i_kernel_sel        = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkCount(input string name, input int actual, input int required);
    assertCount++;
    if (actual != required) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic checkReset(input string name);
    checkCount({name, "_valid"}, int'(o_pixels_data_valid), 0);
    checkCount({name, "_end"},   int'(o_end_frame), 0);
    checkCount({name, "_drop"},  int'(o_drop), 0);
    checkCount({name, "_data"},  int'(o_pixels_data), 0);
  endtask

  // Direct 3x3 neighbourhood evaluation on the pixel grid, neutral value outside the frame.
  task automatic computeGolden(input bit erode, input bit square);
    int acc, v, rr, cc;
    logic [DW-1:0] w;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < FW; c++) begin
        acc = frameBuf[r][c];
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (square || dr == 0 || dc == 0) begin
              rr = r + dr;
              cc = c + dc;
              if (rr < 0 || rr >= H || cc < 0 || cc >= FW) v = erode ? 255 : 0;
              else v = frameBuf[rr][cc];
              if (erode) acc = (v < acc) ? v : acc;
              else acc = (v > acc) ? v : acc;
            end
          end
        end
        golden[r][c] = acc;
      end
    end
    for (int j = 0; j < N; j++) begin
      w = '0;
      for (int i = 0; i < PPW; i++) w[i*PW +: PW] = PW'(golden[j / WPL][(j % WPL) * PPW + i]);
      expData.push_back(w);
      expLast.push_back(j == N - 1);
    end
  endtask

  function automatic logic [DW-1:0] packWord(input int j);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < PPW; i++) w[i*PW +: PW] = PW'(frameBuf[j / WPL][(j % WPL) * PPW + i]);
    return w;
  endfunction

  task automatic sendFrame(input bit erode, input bit square, input int idlePct, input bit flushValid);
    int acceptEdge;
    bit m, k;
    computeGolden(erode, square);
    for (int j = 0; j < N; j++) begin
      for (int g = 0; g < 8 && $urandom_range(99) < idlePct; g++)
        applyStimulus(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
      m = (j == 0) ? erode  : 1'($urandom);
      k = (j == 0) ? square : 1'($urandom);
      acceptEdge = cyc + 1;
      applyStimulus(1'b1, packWord(j), m, k);
      if (j >= WPL + 1) expCycle.push_back(acceptEdge + 2);
      if (j == N - 1)
        for (int f = 1; f <= WPL + 1; f++) expCycle.push_back(acceptEdge + 2 + f);
    end
    for (int f = 0; f < WPL + 1; f++) begin
      applyStimulus(flushValid, DW'($urandom), 1'($urandom), 1'($urandom));
      if (flushValid) expDrops++;
    end
  endtask

  task automatic waitDrain(input string name);
    for (int t = 0; t < 200 && expData.size() > 0; t++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkCount({name, "_pending"}, expData.size(), 0);
  endtask

  task automatic fillFrame(input int value);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < FW; c++) frameBuf[r][c] = value;
  endtask

  task automatic randomFrame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < FW; c++) frameBuf[r][c] = int'($urandom_range(255));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int o0, e0, d0;
    i_reset             = 1'b1;
    i_pixels_data_valid = 1'b0;
    i_pixels_data       = '0;
    i_mode              = 1'b0;
    i_kernel_sel        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    i_reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] dilate cross, single bright pixel");
    e0 = endSeen; o0 = outSeen;
    fillFrame(0);
    frameBuf[1][3] = 255;
    sendFrame(1'b0, 1'b0, 0, 1'b0);
    waitDrain("dilate_cross");
    checkCount("dilate_cross_words", outSeen - o0, N);
    checkCount("dilate_cross_end", endSeen - e0, 1);

    $display("[TB] dilate square, single bright pixel");
    sendFrame(1'b0, 1'b1, 0, 1'b0);
    waitDrain("dilate_square");

    $display("[TB] erode cross, all-ones and single dark corner");
    fillFrame(255);
    sendFrame(1'b1, 1'b0, 0, 1'b0);
    frameBuf[0][0] = 0;
    sendFrame(1'b1, 1'b0, 0, 1'b0);
    waitDrain("erode_cross");

    $display("[TB] random frames with idle gaps");
    for (int f = 0; f < 8; f++) begin
      randomFrame();
      sendFrame(1'($urandom), 1'($urandom), 30, 1'($urandom));
    end
    waitDrain("random");

    $display("[TB] reset in the middle of a frame");
    ignoreOut = 1'b1;
    randomFrame();
    for (int j = 0; j < 5; j++) applyStimulus(1'b1, packWord(j), 1'($urandom), 1'($urandom));
    i_reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    ignoreOut = 1'b0;
    quiet     = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkReset("reset_mid_frame");
    i_reset = 1'b0;
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    quiet = 1'b0;
    randomFrame();
    sendFrame(1'b1, 1'b1, 0, 1'b0);
    waitDrain("after_reset");

    $display("[TB] back-to-back frames with valid held high");
    o0 = outSeen; e0 = endSeen; d0 = dropSeen;
    randomFrame();
    sendFrame(1'b0, 1'b0, 0, 1'b1);
    randomFrame();
    sendFrame(1'b1, 1'b1, 0, 1'b1);
    waitDrain("back_to_back");
    checkCount("back_to_back_words", outSeen - o0, 2 * N);
    checkCount("back_to_back_ends", endSeen - e0, 2);
    checkCount("back_to_back_drops", dropSeen - d0, 2 * (WPL + 1));

    checkCount("total_drops", dropSeen, expDrops);
    checkCount("latency_schedule_left", expCycle.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
